// File: rtl/sonar_scheduler.sv
// Round-robin HC-SR04 scheduler: one trigger/echo-timing datapath time-shared
// across NUM_SENSORS sensors, publishing one tagged distance result per slot.
module sonar_scheduler #(
  parameter int NUM_SENSORS     = 4,
  parameter int CLK_PER_US      = 40,
  parameter int TRIG_US         = 20,
  parameter int SLOT_US         = 60000,
  parameter int RISE_TIMEOUT_US = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trig,
  output logic [11:0]                    dist_us,
  output logic [$clog2(NUM_SENSORS)-1:0] dist_id,
  output logic                           dist_timeout,
  output logic                           dist_valid,
  output logic                           busy
);

  localparam int IDW = $clog2(NUM_SENSORS);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] GUARD     = 3'd4;

  localparam logic [5:0]             PRESC_LAST = 6'(CLK_PER_US - 1);
  localparam logic [15:0]            TRIG_LAST  = 16'(TRIG_US - 1);
  localparam logic [15:0]            SLOT_LAST  = 16'(SLOT_US - 1);
  localparam logic [11:0]            RISE_LAST  = 12'(RISE_TIMEOUT_US - 1);
  localparam logic [11:0]            WIDTH_MAX  = 12'hFFF;
  localparam logic [IDW-1:0]         IDX_LAST   = IDW'(NUM_SENSORS - 1);
  localparam logic [NUM_SENSORS-1:0] ONE_HOT0   = {{(NUM_SENSORS-1){1'b0}}, 1'b1};

  logic [2:0]             state_r, state_s, slot_next_s;
  logic [IDW-1:0]         idx_r, idx_wrap_s, idx_next_s;
  logic [5:0]             presc_r;
  logic [15:0]            slot_r;
  logic [11:0]            width_r;
  logic [NUM_SENSORS-1:0] sync1_r, sync2_r;
  logic                   tick_s, echo_s, slot_end_s;
  logic                   enter_trig_s, adv_s, emit_s, emit_to_s;
  logic                   width_clr_s, width_inc_s;
  logic [11:0]            emit_us_s;

  assign tick_s      = (presc_r == PRESC_LAST);
  assign echo_s      = sync2_r[idx_r];
  assign slot_end_s  = tick_s && (slot_r == SLOT_LAST);
  assign idx_wrap_s  = (idx_r == IDX_LAST) ? {IDW{1'b0}} : idx_r + 1'b1;
  assign idx_next_s  = adv_s ? idx_wrap_s : idx_r;
  assign slot_next_s = enable ? TRIG : IDLE;

  // Next-state and per-slot actions; width_r doubles as the rise timer in WAIT_RISE.
  always_comb begin
    state_s      = state_r;
    enter_trig_s = 1'b0;
    adv_s        = 1'b0;
    emit_s       = 1'b0;
    emit_us_s    = 12'd0;
    emit_to_s    = 1'b0;
    width_clr_s  = 1'b0;
    width_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s      = TRIG;
          enter_trig_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      TRIG: begin
        if (tick_s && (slot_r == TRIG_LAST)) begin
          state_s     = WAIT_RISE;
          width_clr_s = 1'b1;
        end else begin
          state_s = TRIG;
        end
      end
      WAIT_RISE: begin
        if (slot_end_s) begin
          emit_s       = 1'b1;
          emit_us_s    = WIDTH_MAX;
          emit_to_s    = 1'b1;
          adv_s        = 1'b1;
          state_s      = slot_next_s;
          enter_trig_s = enable;
        end else if (echo_s) begin
          state_s     = MEASURE;
          width_clr_s = 1'b1;
        end else if (tick_s && (width_r == RISE_LAST)) begin
          emit_s    = 1'b1;
          emit_us_s = WIDTH_MAX;
          emit_to_s = 1'b1;
          state_s   = GUARD;
        end else begin
          width_inc_s = tick_s;
        end
      end
      MEASURE: begin
        if (slot_end_s) begin
          emit_s       = 1'b1;
          emit_us_s    = width_r;
          emit_to_s    = 1'b1;
          adv_s        = 1'b1;
          state_s      = slot_next_s;
          enter_trig_s = enable;
        end else if (!echo_s) begin
          emit_s    = 1'b1;
          emit_us_s = width_r;
          emit_to_s = 1'b0;
          state_s   = GUARD;
        end else if (tick_s && (width_r == (WIDTH_MAX - 12'd1))) begin
          emit_s    = 1'b1;
          emit_us_s = WIDTH_MAX;
          emit_to_s = 1'b1;
          state_s   = GUARD;
        end else begin
          width_inc_s = tick_s;
        end
      end
      GUARD: begin
        if (slot_end_s) begin
          adv_s        = 1'b1;
          state_s      = slot_next_s;
          enter_trig_s = enable;
        end else begin
          state_s = GUARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Two-flop synchronisers on every echo pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {NUM_SENSORS{1'b0}};
      sync2_r <= {NUM_SENSORS{1'b0}};
    end else begin
      sync1_r <= echo;
      sync2_r <= sync1_r;
    end
  end

  // FSM state, sensor index and the us/slot/width counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= {IDW{1'b0}};
      presc_r <= 6'd0;
      slot_r  <= 16'd0;
      width_r <= 12'd0;
    end else begin
      state_r <= state_s;
      if (adv_s) idx_r <= idx_wrap_s;
      presc_r <= (enter_trig_s || tick_s) ? 6'd0 : presc_r + 6'd1;
      if (enter_trig_s) slot_r <= 16'd0;
      else if (tick_s && (state_r != IDLE)) slot_r <= slot_r + 16'd1;
      if (width_clr_s) width_r <= 12'd0;
      else if (width_inc_s) width_r <= width_r + 12'd1;
    end
  end

  // Registered outputs; trig drops asynchronously with reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig         <= {NUM_SENSORS{1'b0}};
      busy         <= 1'b0;
      dist_valid   <= 1'b0;
      dist_us      <= 12'd0;
      dist_id      <= {IDW{1'b0}};
      dist_timeout <= 1'b0;
    end else begin
      trig       <= (state_s == TRIG) ? (ONE_HOT0 << idx_next_s) : {NUM_SENSORS{1'b0}};
      busy       <= (state_s != IDLE);
      dist_valid <= emit_s;
      if (emit_s) begin
        dist_us      <= emit_us_s;
        dist_id      <= idx_r;
        dist_timeout <= emit_to_s;
      end
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler: a short-slot instance with an echo
// responder, and a long-slot instance for the stuck-high echo case.
module tb_sonar_scheduler;

  typedef struct { int id; int us; int to; int cyc; } res_t;
  typedef struct { int id; int cyc; } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, enable_a, reset_b, enable_b;
  logic [3:0] echo_a, echo_b, trig_a, trig_b;
  logic [11:0] dist_us_a, dist_us_b;
  logic [1:0] dist_id_a, dist_id_b;
  logic       dist_timeout_a, dist_timeout_b, dist_valid_a, dist_valid_b, busy_a, busy_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int multi_a = 0;
  int multi_b = 0;
  logic [3:0] trig_prev_a = 4'b0;
  logic [3:0] trig_prev_b = 4'b0;
  res_t res_a[$], res_b[$];
  evt_t rise_a[$], fall_a[$], rise_b[$];
  int mode_a[4], dly_a[4], wid_a[4];

  sonar_scheduler #(.NUM_SENSORS(4), .CLK_PER_US(4), .TRIG_US(2), .SLOT_US(100),
                    .RISE_TIMEOUT_US(10)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .echo(echo_a), .trig(trig_a),
    .dist_us(dist_us_a), .dist_id(dist_id_a), .dist_timeout(dist_timeout_a),
    .dist_valid(dist_valid_a), .busy(busy_a));

  sonar_scheduler #(.NUM_SENSORS(4), .CLK_PER_US(4), .TRIG_US(2), .SLOT_US(6000),
                    .RISE_TIMEOUT_US(10)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .echo(echo_b), .trig(trig_b),
    .dist_us(dist_us_b), .dist_id(dist_id_b), .dist_timeout(dist_timeout_b),
    .dist_valid(dist_valid_b), .busy(busy_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bit_id(input logic [3:0] v);
    bit_id = 0;
    for (int i = 0; i < 4; i++) if (v[i]) bit_id = i;
  endfunction

  function automatic res_t mk_res(input int id, input int us, input int to, input int c);
    mk_res.id = id; mk_res.us = us; mk_res.to = to; mk_res.cyc = c;
  endfunction

  function automatic evt_t mk_evt(input int id, input int c);
    mk_evt.id = id; mk_evt.cyc = c;
  endfunction

  function automatic int cur_size(input int sel);
    case (sel)
      0: return res_a.size();
      1: return rise_a.size();
      2: return res_b.size();
      default: return rise_b.size();
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorders: results, trigger edges and multi-hot trigger detection.
  always @(negedge clk) begin
    if (dist_valid_a) res_a.push_back(mk_res(int'(dist_id_a), int'(dist_us_a), int'(dist_timeout_a), cyc));
    if ((trig_a & ~trig_prev_a) != 4'b0) rise_a.push_back(mk_evt(bit_id(trig_a & ~trig_prev_a), cyc));
    if ((trig_prev_a & ~trig_a) != 4'b0) fall_a.push_back(mk_evt(bit_id(trig_prev_a & ~trig_a), cyc));
    if ($countones(trig_a) > 1) multi_a <= multi_a + 1;
    trig_prev_a <= trig_a;
    if (dist_valid_b) res_b.push_back(mk_res(int'(dist_id_b), int'(dist_us_b), int'(dist_timeout_b), cyc));
    if ((trig_b & ~trig_prev_b) != 4'b0) rise_b.push_back(mk_evt(bit_id(trig_b & ~trig_prev_b), cyc));
    if ($countones(trig_b) > 1) multi_b <= multi_b + 1;
    trig_prev_b <= trig_b;
  end

  // Echo responder for dut_a: after a trigger falls, wait dly us then hold echo wid us.
  initial begin : responder
    logic [3:0] prev;
    int id;
    echo_a = 4'b0;
    prev = 4'b0;
    forever begin
      @(negedge clk);
      if (prev != 4'b0 && trig_a == 4'b0) begin
        id = bit_id(prev);
        prev = 4'b0;
        if (mode_a[id] == 1) begin
          repeat (dly_a[id] * 4) @(negedge clk);
          echo_a[id] = 1'b1;
          repeat (wid_a[id] * 4) @(negedge clk);
          echo_a[id] = 1'b0;
        end
      end else begin
        prev = trig_a;
      end
    end
  end

  task automatic wait_count(input int sel, input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (cur_size(sel) < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (cur_size(sel) < n) check_eq(tag, cur_size(sel), n);
  endtask

  task automatic run_a();
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int exp_us[5] = '{37, 20, 30, 40, 37};
    int t, busy_cyc, n;
    for (int i = 0; i < 4; i++) begin mode_a[i] = 1; dly_a[i] = 5; end
    wid_a[0] = 37; wid_a[1] = 20; wid_a[2] = 30; wid_a[3] = 40;
    enable_a = 1'b1;
    wait_count(0, 5, 3000, "rr_timeout");
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rr%0d_id", i), res_a[i].id, exp_id[i]);
      check_eq($sformatf("rr%0d_us", i), res_a[i].us, exp_us[i]);
      check_eq($sformatf("rr%0d_to", i), res_a[i].to, 0);
    end
    mode_a[2] = 0;
    check_eq("basic_trig_len", fall_a[0].cyc - rise_a[0].cyc, 8);
    check_eq("basic_valid_lat", res_a[0].cyc - rise_a[0].cyc, 179);
    check_eq("basic_slot_len", rise_a[1].cyc - rise_a[0].cyc, 400);
    check_eq("basic_next_id", rise_a[1].id, 1);
    // No echo on sensor 2
    wait_count(0, 7, 1200, "noecho_timeout");
    check_eq("noecho_id", res_a[6].id, 2);
    check_eq("noecho_us", res_a[6].us, 4095);
    check_eq("noecho_to", res_a[6].to, 1);
    check_eq("noecho_lat", res_a[6].cyc - rise_a[6].cyc, 48);
    wait_count(1, 8, 500, "noecho_next_timeout");
    check_eq("noecho_slot_len", rise_a[7].cyc - rise_a[6].cyc, 400);
    // Enable drop in sensor 1 MEASURE
    wait_count(1, 10, 1000, "drop_rise_timeout");
    repeat (60) @(negedge clk);
    enable_a = 1'b0;
    wait_count(0, 10, 400, "drop_res_timeout");
    check_eq("drop_id", res_a[9].id, 1);
    check_eq("drop_us", res_a[9].us, 20);
    check_eq("drop_to", res_a[9].to, 0);
    t = 0;
    while (busy_a && t < 600) begin @(negedge clk); #1; t++; end
    busy_cyc = cyc;
    check_eq("drop_busy_low", busy_a, 0);
    check_eq("drop_slot_done", busy_cyc - rise_a[9].cyc, 400);
    repeat (100) @(negedge clk);
    check_eq("idle_no_rise", rise_a.size(), 10);
    check_eq("idle_no_res", res_a.size(), 10);
    check_eq("idle_trig", trig_a, 0);
    enable_a = 1'b1;
    wait_count(1, 11, 100, "resume_timeout");
    check_eq("resume_id", rise_a[10].id, 2);
    // Async reset while trig[3] is high
    mode_a[3] = 0;
    wait_count(1, 12, 1000, "rst_rise_timeout");
    check_eq("rst_pre_trig", trig_a, 4'b1000);
    n = res_a.size();
    reset_a = 1'b1;
    #1;
    check_eq("rst_trig", trig_a, 0);
    check_eq("rst_valid", dist_valid_a, 0);
    check_eq("rst_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    wait_count(1, 13, 100, "rst_restart_timeout");
    check_eq("rst_restart_id", rise_a[12].id, 0);
    check_eq("rst_no_partial", res_a.size(), n);
  endtask

  task automatic run_b();
    repeat (2) @(negedge clk);
    echo_b = 4'b0010;
    enable_b = 1'b1;
    wait_count(2, 2, 50000, "stuck_timeout");
    check_eq("stuck_s0_id", res_b[0].id, 0);
    check_eq("stuck_s0_us", res_b[0].us, 4095);
    check_eq("stuck_s0_to", res_b[0].to, 1);
    check_eq("stuck_id", res_b[1].id, 1);
    check_eq("stuck_us", res_b[1].us, 4095);
    check_eq("stuck_to", res_b[1].to, 1);
    check_eq("stuck_lat", res_b[1].cyc - rise_b[1].cyc, 16388);
    wait_count(3, 3, 30000, "stuck_next_timeout");
    check_eq("stuck_next_id", rise_b[2].id, 2);
    check_eq("stuck_slot_len", rise_b[2].cyc - rise_b[1].cyc, 24000);
    wait_count(2, 3, 200, "stuck_next_res_timeout");
    check_eq("stuck_next_res_id", res_b[2].id, 2);
    check_eq("stuck_next_lat", res_b[2].cyc - rise_b[2].cyc, 48);
    enable_b = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    enable_a = 1'b0; enable_b = 1'b0;
    echo_b = 4'b0;
    for (int i = 0; i < 4; i++) begin mode_a[i] = 0; dly_a[i] = 0; wid_a[i] = 0; end
    repeat (4) @(negedge clk);
    check_eq("reset_trig", trig_a, 0);
    check_eq("reset_dist_us", dist_us_a, 0);
    check_eq("reset_dist_id", dist_id_a, 0);
    check_eq("reset_dist_to", dist_timeout_a, 0);
    check_eq("reset_valid", dist_valid_a, 0);
    check_eq("reset_busy", busy_a, 0);
    reset_a = 1'b0; reset_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_busy", busy_a, 0);
    fork
      run_a();
      run_b();
    join
    check_eq("onehot_a", multi_a, 0);
    check_eq("onehot_b", multi_b, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
